// File: rtl/digit_serial_mul.sv
// rtl/digit_serial_mul.sv - digit-serial unsigned WIDTH x WIDTH multiplier built on one mul2x2
module mul2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  assign p = a * b;
endmodule

module digit_serial_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_l;
  logic [WIDTH-1:0]   b_l;
  logic [2*WIDTH-1:0] acc;
  logic [IW-1:0]      i;
  logic [IW-1:0]      j;

  logic [1:0]         da;
  logic [1:0]         db;
  logic [3:0]         pp;
  logic [IW:0]        sh;
  logic [2*WIDTH-1:0] pp_shift;

  // Digit pair select; the digit weight is 2*(i+j) and needs one extra bit of range.
  always_comb begin
    da       = 2'(a_l >> {i, 1'b0});
    db       = 2'(b_l >> {j, 1'b0});
    sh       = {1'b0, i} + {1'b0, j};
    pp_shift = (2*WIDTH)'(pp) << {sh, 1'b0};
  end

  mul2x2 u_mul2x2 (
    .a (da),
    .b (db),
    .p (pp)
  );

  assign product = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
      a_l       <= '0;
      b_l       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_l      <= a;
            b_l      <= b;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc + pp_shift;
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              i         <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/digit_serial_mul.md
Name: digit_serial_mul

Overview:
- Multi-cycle unsigned WIDTH x WIDTH multiplier that sits directly downstream of the codebase's `mul2x2` block.
- Contains one `mul2x2` instance. Each cycle it feeds one 2-bit digit pair into that instance, shifts the 4-bit partial product and adds it into a 2*WIDTH accumulator.
- Used as a low-area processing-element multiplier in the systolic array. Valid/ready handshakes on both sides; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2. D = WIDTH/2 digits per operand.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands a/b valid this cycle.
- in_ready  output  1  block idle and able to accept operands.
- a  input  WIDTH  unsigned multiplicand.
- b  input  WIDTH  unsigned multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  unsigned a*b.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (rst=1 at a clock edge), regardless of current state:
  - state=IDLE; in_ready=1, out_valid=0, busy=0.
  - product/accumulator=0; digit indices i=j=0; latched operands=0.
  - Reset mid-operation discards that operation; no output is produced for it.
- States: IDLE, CALC, DONE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1, out_valid=0.
  - On edge with in_valid=1: latch a,b; clear accumulator; i=j=0; go to CALC.
  - in_valid=0: remain in IDLE.
- CALC:
  - in_ready=0. in_valid and a/b are ignored.
  - Each edge: acc <= acc + (mul2x2(a_l[2i+1:2i], b_l[2j+1:2j]) << 2*(i+j)).
  - Then j increments. When j==D-1, j wraps to 0 and i increments.
  - On the edge where i==D-1 and j==D-1, the final add is performed, i/j return to 0, and state goes to DONE.
  - Exactly D*D accumulate edges (16 for WIDTH=8; 1 for WIDTH=2).
- DONE:
  - out_valid=1; product=acc, held stable.
  - On edge with out_ready=1: go to IDLE; out_valid drops the next cycle.
  - out_ready=0: hold indefinitely with product unchanged (backpressure).
- Latency: accepting edge at t0 → out_valid first high after edge t0+D*D.
- Throughput: with in_valid and out_ready held high, a new operation is accepted every D*D+2 cycles. The handshake-out edge returns to IDLE; the next edge accepts.
- Arithmetic:
  - Unsigned throughout. The accumulator is 2*WIDTH bits.
  - The maximum partial sum is (2^WIDTH-1)^2 < 2^(2*WIDTH), so overflow cannot occur.
  - The shift is performed at full 2*WIDTH width before the add.
- Simultaneous rst and any handshake: rst wins.
- in_valid asserted in CALC/DONE is not captured. Operands must be re-presented once in_ready=1.
- `mul2x2` is instantiated unmodified; the digit mux uses indices i and j.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, busy=0, product=0x0000; no operation accepted.
- WIDTH=8, a=0xFF, b=0xFF, out_ready=1 → out_valid rises exactly 16 cycles after the accept edge with product=0xFE01, held for 1 cycle.
- Corner operands:
  - a=0x00, b=0xA5 → 0x0000.
  - a=0x01, b=0xFF → 0x00FF.
  - a=0x80, b=0x02 → 0x0100.
  - a=0x3C, b=0x5A → 0x1518.
  - Also run 1000 random pairs against a reference product.
- Backpressure: a=0x12, b=0x34 with out_ready=0 for 5 cycles after out_valid → product stays 0x03A8 and in_ready stays 0. A new in_valid with a=0x77 is ignored. Then out_ready=1 → IDLE the next cycle.
- Mid-operation reset: accept a=0xFF, b=0xFF; assert rst on the 7th CALC cycle → all outputs return to reset values and out_valid never fires. Next op a=0x03, b=0x05 → 0x000F.
- Back-to-back: in_valid and out_ready held high with (0x10,0x10) then (0x0F,0x11) → products 0x0100 then 0x00FF; accepts 18 cycles apart. Repeat with WIDTH=2: a=3, b=3 → 9 after 1 CALC cycle.
